comparator: RTL and testbench

COMPARATOR -- requirements
Module: comparator

---
 rtl/comparator.sv | 134 +++++++++++++
 tb/tb_comparator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator.sv
// -----------------------------------------------------------------------------
// comparator
//   Registered RISC-V branch condition evaluator. It takes the ALU flags
//   (z, s, v, c) and the branch funct3. One clock later it reports whether the
//   branch is taken, whether the request was valid, and whether funct3 was an
//   unused encoding (010/011).
//
// Optional feature macro: COMPARATOR_STATS_EN
//   When this macro is defined, the module adds a saturating taken-branch
//   counter of width CNT_W and exposes it on the taken_count port.
//
// Ports
//   clk           : single clock, all state changes on the rising edge
//   rst_n         : asynchronous active-low reset
//   z, s, v, c    : ALU zero, sign, signed-overflow and carry (no borrow) flags
//   funct3        : branch selector (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   in_valid      : qualifies flags/funct3 this cycle
//   output_branch : registered taken decision (0 when not valid or illegal)
//   out_valid     : in_valid delayed by one cycle
//   illegal       : registered flag for funct3 010/011 with in_valid high
//   taken_count   : saturating taken count (only with COMPARATOR_STATS_EN)
// -----------------------------------------------------------------------------
module comparator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z,
  input  logic             s,
  input  logic             v,
  input  logic             c,
  input  logic [2:0]       funct3,
  input  logic             in_valid,
  output logic             output_branch,
  output logic             out_valid,
`ifdef COMPARATOR_STATS_EN
  output logic             illegal,
  output logic [CNT_W-1:0] taken_count
`else
  output logic             illegal
`endif
);

  // Branch condition decode. Each case reads only the flags that its
  // condition needs, so the other flags cannot affect the result.
  function automatic logic branch_cond(input logic [2:0] f3, input logic fz,
                                       input logic fs, input logic fv,
                                       input logic fc);
    logic res;
    case (f3)
      3'b000:  res = fz;            // BEQ
      3'b001:  res = ~fz;           // BNE
      3'b100:  res = fs ^ fv;       // BLT
      3'b101:  res = ~(fs ^ fv);    // BGE
      3'b110:  res = ~fc;           // BLTU
      3'b111:  res = fc;            // BGEU
      default: res = 1'b0;          // 010, 011 and any unknown code
    endcase
    return res;
  endfunction

  // Unused funct3 encodings in the branch opcode space.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    logic res;
    case (f3)
      3'b010:  res = 1'b1;
      3'b011:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic taken_s;
  logic illegal_s;
  logic branch_r;
  logic valid_r;
  logic illegal_r;

  // Qualified next-state values. Both are forced to 0 when in_valid is low.
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    if (in_valid) begin
      taken_s   = branch_cond(funct3, z, s, v, c);
      illegal_s = is_illegal_f3(funct3);
    end else begin
      taken_s   = 1'b0;
      illegal_s = 1'b0;
    end
  end

  // Decision pipeline register. Reset clears it immediately, so any
  // decision that is still pending is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_r  <= 1'b0;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      branch_r  <= taken_s;
      valid_r   <= in_valid;
      illegal_r <= illegal_s;
    end
  end

  assign output_branch = branch_r;
  assign out_valid     = valid_r;
  assign illegal       = illegal_r;

`ifdef COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Saturating taken counter. Once it reaches all-ones it holds there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (taken_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign taken_count = count_r;
`else
  // CNT_W only sizes the counter. Without the stats feature, this signal
  // keeps the parameter referenced.
  logic [CNT_W-1:0] unused_cnt_w_s;
  assign unused_cnt_w_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_comparator.sv
module tb_comparator;

  logic       clk;
  logic       rst_n;
  logic       z, s, v, c;
  logic [2:0] funct3;
  logic       in_valid;
  logic       output_branch;
  logic       out_valid;
  logic       illegal;
`ifdef COMPARATOR_STATS_EN
  logic [1:0] taken_count;
`endif

  int checks;
  int failures;

  comparator #(.CNT_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .z             (z),
    .s             (s),
    .v             (v),
    .c             (c),
    .funct3        (funct3),
    .in_valid      (in_valid),
    .output_branch (output_branch),
    .out_valid     (out_valid),
`ifdef COMPARATOR_STATS_EN
    .illegal       (illegal),
    .taken_count   (taken_count)
`else
    .illegal       (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] f3;
    logic       fz, fs, fv, fc, iv;
    logic       exp_br, exp_il;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic fz, input logic fs,
                       input logic fv, input logic fc, input logic iv);
    funct3 = f3; z = fz; s = fs; v = fv; c = fc; in_valid = iv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase
  logic [31:0] rs1, rs2, diff;
  logic        m_br, m_iv, m_il;
  int          m_cnt;

  initial begin
    checks = 0;
    failures = 0;
    m_cnt = 0;

    // ---------------- Reset behaviour ----------------
    rst_n = 1'b0;
    drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("rst_branch_t0", {31'd0, output_branch}, 32'd0);
    check("rst_valid_t0", {31'd0, out_valid}, 32'd0);
    check("rst_illegal_t0", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_branch_hold", {31'd0, output_branch}, 32'd0);
      check("rst_valid_hold", {31'd0, out_valid}, 32'd0);
    end
`ifdef COMPARATOR_STATS_EN
    check("rst_count", {30'd0, taken_count}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("post_rst_branch", {31'd0, output_branch}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_illegal", {31'd0, illegal}, 32'd0);

    // Asynchronous clear in mid-stream, with no pulse after release
    drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("pre_async_branch", {31'd0, output_branch}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_branch", {31'd0, output_branch}, 32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("no_pulse_valid", {31'd0, out_valid}, 32'd0);
    check("no_pulse_branch", {31'd0, output_branch}, 32'd0);

    // ---------------- Directed table ----------------
    // Sweep with all flags at 0
    tbl.push_back({3'b000, 5'b00001, 2'b00});
    tbl.push_back({3'b001, 5'b00001, 2'b10});
    tbl.push_back({3'b010, 5'b00001, 2'b01});
    tbl.push_back({3'b011, 5'b00001, 2'b01});
    tbl.push_back({3'b100, 5'b00001, 2'b00});
    tbl.push_back({3'b101, 5'b00001, 2'b10});
    tbl.push_back({3'b110, 5'b00001, 2'b10});
    tbl.push_back({3'b111, 5'b00001, 2'b00});
    // Signed conditions (flag order: z s v c iv)
    tbl.push_back({3'b100, 5'b01001, 2'b10});
    tbl.push_back({3'b100, 5'b01101, 2'b00});
    tbl.push_back({3'b101, 5'b01001, 2'b00});
    tbl.push_back({3'b101, 5'b01101, 2'b10});
    // Unsigned conditions
    tbl.push_back({3'b111, 5'b00011, 2'b10});
    tbl.push_back({3'b111, 5'b00001, 2'b00});
    tbl.push_back({3'b110, 5'b00011, 2'b00});
    tbl.push_back({3'b110, 5'b00001, 2'b10});
    // Valid gating
    tbl.push_back({3'b001, 5'b00000, 2'b00});
    tbl.push_back({3'b010, 5'b11110, 2'b00});
    // Unselected flags have no effect
    tbl.push_back({3'b000, 5'b11111, 2'b10});
    tbl.push_back({3'b001, 5'b11111, 2'b00});
    tbl.push_back({3'b110, 5'b11101, 2'b10});
    tbl.push_back({3'b100, 5'b10011, 2'b00});
    tbl.push_back({3'b011, 5'b11111, 2'b01});

    // Reset clears the counter before the table runs.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_cnt = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].f3, tbl[i].fz, tbl[i].fs, tbl[i].fv, tbl[i].fc, tbl[i].iv);
      tick();
      check($sformatf("tbl%0d_branch", i), {31'd0, output_branch}, {31'd0, tbl[i].exp_br});
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].iv});
      check($sformatf("tbl%0d_illegal", i), {31'd0, illegal}, {31'd0, tbl[i].exp_il});
      if (tbl[i].exp_br && m_cnt < 3) m_cnt++;
`ifdef COMPARATOR_STATS_EN
      check($sformatf("tbl%0d_count", i), {30'd0, taken_count}, m_cnt);
`endif
    end

`ifdef COMPARATOR_STATS_EN
    // Five taken BEQ in a row with a 2-bit counter: 1,2,3,3,3
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check($sformatf("sat%0d", i), {30'd0, taken_count}, (i < 3) ? i + 1 : 3);
    end
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sat_not_taken", {30'd0, taken_count}, 32'd3);
    m_cnt = 3;
`endif

    // ---------------- Random vs operand-level model ----------------
    for (int n = 0; n < 400; n++) begin
      rs1 = $urandom;
      case ($urandom_range(0, 3))
        0: rs2 = rs1;
        1: rs2 = rs1 ^ 32'h8000_0000;
        2: rs2 = $urandom_range(0, 7);
        default: rs2 = $urandom;
      endcase
      diff = rs1 - rs2;
      funct3 = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      z = (rs1 == rs2);
      s = diff[31];
      v = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
      c = (rs1 >= rs2);
      case (funct3)
        3'd0: m_br = (rs1 == rs2);
        3'd1: m_br = (rs1 != rs2);
        3'd4: m_br = ($signed(rs1) < $signed(rs2));
        3'd5: m_br = ($signed(rs1) >= $signed(rs2));
        3'd6: m_br = (rs1 < rs2);
        3'd7: m_br = (rs1 >= rs2);
        default: m_br = 1'b0;
      endcase
      m_br = m_br && in_valid;
      m_iv = in_valid;
      m_il = in_valid && (funct3 == 3'd2 || funct3 == 3'd3);
      if (m_br && m_cnt < 3) m_cnt++;
      tick();
      check($sformatf("rnd%0d_branch", n), {31'd0, output_branch}, {31'd0, m_br});
      check($sformatf("rnd%0d_valid", n), {31'd0, out_valid}, {31'd0, m_iv});
      check($sformatf("rnd%0d_illegal", n), {31'd0, illegal}, {31'd0, m_il});
`ifdef COMPARATOR_STATS_EN
      check($sformatf("rnd%0d_count", n), {30'd0, taken_count}, m_cnt);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
